// File: rtl/hps_bus_master.sv
// Initiator end of the 16-bit HPS command bus: strobes a command word plus N data words
// and returns each response word two cycles after its strobe. Define HPS_BUS_MASTER_TIMEOUT_EN
// to abort transactions whose strobe is held off by bus_wait for TIMEOUT cycles.
module hps_bus_master #(
  parameter int unsigned GAP     = 2,
  parameter int unsigned SETUP   = 1,
  parameter int unsigned END_GAP = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_cmd,
  input  logic [9:0]  req_len,
  input  logic [1:0]  req_sel,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [1:0]  bus_en,
  output logic        bus_strobe,
  output logic [15:0] bus_din,
  input  logic [15:0] bus_dout,
  input  logic        bus_wait
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCmd,
    StGap,
    StData,
    StCapt,
    StEnd
  } state_e;

  localparam logic [15:0] SetupLast = 16'(SETUP - 1);
  localparam logic [15:0] GapLast   = 16'(GAP - 1);
  localparam logic [15:0] EndLast   = 16'(END_GAP - 1);

  state_e      state_q, state_d;
  state_e      after_gap;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  rem_q, rem_d;
  logic [15:0] cmd_q, cmd_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] din_q, din_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        abort_q, abort_d;

`ifdef HPS_BUS_MASTER_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);
  logic [31:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    rem_d      = rem_q;
    cmd_d      = cmd_q;
    sel_d      = sel_q;
    din_d      = din_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    abort_d    = abort_q;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    bus_strobe = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    after_gap  = (rem_q != 10'd0) ? StData : StEnd;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        if (req_valid) begin
          cmd_d   = req_cmd;
          rem_d   = req_len;
          sel_d   = (req_sel == 2'b00) ? 2'b01 : req_sel;
          abort_d = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q >= SetupLast) begin
          cnt_d   = '0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        cnt_d = '0;
        if (!bus_wait) begin
          bus_strobe = 1'b1;
          din_d      = cmd_q;
          state_d    = StGap;
        end
      end
      StGap: begin
        if (cnt_q >= GapLast) begin
          cnt_d   = '0;
          state_d = after_gap;
        end
      end
      StData: begin
        cnt_d = '0;
        if (wr_valid && !bus_wait) begin
          bus_strobe = 1'b1;
          wr_ready   = 1'b1;
          din_d      = wr_data;
          rem_d      = rem_q - 10'd1;
          state_d    = StCapt;
        end
      end
      StCapt: begin
        // Response is sampled here; this cycle also serves as the first gap cycle.
        rd_valid_d = 1'b1;
        rd_data_d  = bus_dout;
        if (GAP <= 1) begin
          cnt_d   = '0;
          state_d = after_gap;
        end else begin
          cnt_d   = 16'd1;
          state_d = StGap;
        end
      end
      StEnd: begin
        done = (cnt_q == 16'd0) && !abort_q;
        if (cnt_q >= EndLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

`ifdef HPS_BUS_MASTER_TIMEOUT_EN
    to_d = to_q;
    if (state_q == StIdle || bus_strobe) begin
      to_d = '0;
    end else if ((state_q == StCmd || state_q == StData) && bus_wait) begin
      to_d = to_q + 32'd1;
      if (to_q == TimeoutLast) begin
        err     = 1'b1;
        abort_d = 1'b1;
        to_d    = '0;
        cnt_d   = '0;
        state_d = StEnd;
      end
    end
`endif
  end

  always_comb begin
    bus_en = 2'b00;
    if (state_q inside {StSetup, StCmd, StGap, StData, StCapt}) begin
      bus_en = sel_q;
    end
  end

  assign bus_din  = din_d;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      cmd_q      <= '0;
      sel_q      <= '0;
      din_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      abort_q    <= 1'b0;
`ifdef HPS_BUS_MASTER_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      cmd_q      <= cmd_d;
      sel_q      <= sel_d;
      din_q      <= din_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      abort_q    <= abort_d;
`ifdef HPS_BUS_MASTER_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_hps_bus_master.sv
// Bench for hps_bus_master: directed transaction table, reset/timeout sequences and random
// transactions checked cycle by cycle against a strobe-schedule model.
module tb_hps_bus_master;

  localparam int GAP     = 2;
  localparam int SETUP   = 1;
  localparam int END_GAP = 2;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready;
  logic [15:0] req_cmd;
  logic [9:0]  req_len;
  logic [1:0]  req_sel;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        done, err;
  logic [1:0]  bus_en;
  logic        bus_strobe;
  logic [15:0] bus_din, bus_dout;
  logic        bus_wait;

  always #5 clk_sys = ~clk_sys;

  hps_bus_master #(
    .GAP    (GAP),
    .SETUP  (SETUP),
    .END_GAP(END_GAP),
    .TIMEOUT(16)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_len   (req_len),
    .req_sel   (req_sel),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .bus_en    (bus_en),
    .bus_strobe(bus_strobe),
    .bus_din   (bus_din),
    .bus_dout  (bus_dout),
    .bus_wait  (bus_wait)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [9:0]  len;
    logic [1:0]  sel;
    int w_lo, w_hi, v_lo, v_hi;
    int e_rdy, e_str, e_wr, e_rd, e_done;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        wait_arr [4096];
  logic        valid_arr[4096];
  logic [15:0] wdata    [1024];
  logic [15:0] resp_arr [1025];
  logic [15:0] last_din = '0;
  logic [15:0] last_rd = '0;

  function automatic logic [39:0] pack_out();
    return {err, bus_en, bus_strobe, bus_din, wr_ready, rd_valid, rd_data, done, req_ready};
  endfunction

  task automatic chk(input string nm, input int c, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h want %h", nm, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_cmd   = '0;
    req_len   = '0;
    req_sel   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    bus_wait  = 1'b0;
    bus_dout  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset    = 1'b0;
    last_din = '0;
    last_rd  = '0;
  endtask

  // Expected strobe cycles follow from the rules alone: first strobe no earlier than SETUP+1,
  // each later one no earlier than GAP+1 after the previous, on the first cycle it is allowed.
  task automatic run_txn(input logic [15:0] cmd, input logic [9:0] len, input logic [1:0] sel,
                         output int o_str, output int o_wr, output int o_rd, output int o_done,
                         output int o_ready);
    int st[1025];
    int t, endc, rdy, ns, nr, k, seen, n;
    bit prev_s, ok, e_s, e_wr, e_rv, e_done, e_ready;
    logic [15:0] e_din, e_rd;
    logic [1:0]  seln, e_en;
    logic [39:0] exp_v;
    n    = int'(len);
    seln = (sel == 2'b00) ? 2'b01 : sel;
    t    = SETUP + 1;
    while (t < 4000 && wait_arr[t]) t++;
    st[0] = t;
    for (int j = 1; j <= n; j++) begin
      t = st[j-1] + GAP + 1;
      while (t < 4000 && (wait_arr[t] || !valid_arr[t])) t++;
      st[j] = t;
    end
    endc = st[n] + GAP + 1;
    rdy  = endc + END_GAP;
    ns = 0; nr = 1; k = 0; seen = 0; prev_s = 0; ok = 1;
    o_str = 0; o_wr = 0; o_rd = 0; o_done = 0; o_ready = -1;
    for (int c = 0; c <= rdy; c++) begin
      bus_dout  = prev_s ? resp_arr[seen-1] : 16'($urandom);
      req_valid = (c == 0) || (c < rdy && $urandom_range(3) == 0);
      req_cmd   = (c == 0) ? cmd : 16'($urandom);
      req_len   = (c == 0) ? len : 10'($urandom);
      req_sel   = (c == 0) ? sel : 2'($urandom);
      bus_wait  = wait_arr[c];
      wr_valid  = valid_arr[c];
      wr_data   = (k < n) ? wdata[k] : 16'($urandom);
      @(negedge clk_sys);
      e_s = 0; e_wr = 0; e_din = last_din;
      if (ns <= n && st[ns] == c) begin
        e_s   = 1;
        e_din = (ns == 0) ? cmd : wdata[ns-1];
        e_wr  = (ns > 0);
        ns++;
      end
      e_rv = 0; e_rd = last_rd;
      if (nr <= n && st[nr] + 2 == c) begin
        e_rv = 1;
        e_rd = resp_arr[nr];
        nr++;
      end
      e_en    = (c >= 1 && c < endc) ? seln : 2'b00;
      e_done  = (c == endc);
      e_ready = (c == 0 || c == rdy);
      exp_v   = {1'b0, e_en, e_s, e_din, e_wr, e_rv, e_rd, e_done, e_ready};
      if (ok) begin
        chk("cycle", c, pack_out(), exp_v);
        if (pack_out() !== exp_v) ok = 0;
      end
      last_din = e_din;
      last_rd  = e_rd;
      o_str  += int'(bus_strobe);
      o_wr   += int'(wr_ready);
      o_rd   += int'(rd_valid);
      o_done += int'(done);
      if (c > 0 && req_ready && o_ready < 0) o_ready = c;
      prev_s = bus_strobe;
      if (bus_strobe) seen++;
      if (wr_ready) k++;
      @(posedge clk_sys);
      #1;
    end
    idle_inputs();
    if (!ok) do_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int o_str, o_wr, o_rd, o_done, o_ready;
    int cnt_done, cnt_notready, err_c, n_err, rdy_c, n_str, run;
    logic [1:0] en17, en18;
    bit w;

    tbl[0] = '{16'h001E, 10'd2,    2'b01, -1, -2, -1, -2, 13,   3,    2,    2,    1};
    tbl[1] = '{16'h0016, 10'd3,    2'b10, -1, -2, -1, -2, 16,   4,    3,    3,    1};
    tbl[2] = '{16'h0001, 10'd0,    2'b00, -1, -2, -1, -2, 7,    1,    0,    0,    1};
    tbl[3] = '{16'h0042, 10'd3,    2'b11, 8,  17, 21, 25, 31,   4,    3,    3,    1};
    tbl[4] = '{16'h0FFF, 10'd1023, 2'b01, -1, -2, -1, -2, 3076, 1024, 1023, 1023, 1};
    tbl[5] = '{16'h0077, 10'd1,    2'b01, 0,  4,  -1, -2, 13,   2,    1,    1,    1};
    tbl[6] = '{16'h0055, 10'd2,    2'b10, 3,  4,  -1, -2, 13,   3,    2,    2,    1};

    idle_inputs();
    repeat (3) tick();
    chk("reset_state", 0, pack_out(), {1'b0, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1});
    reset    = 1'b0;
    last_din = '0;
    last_rd  = '0;

    for (int i = 0; i < 7; i++) begin
      for (int t = 0; t < 4096; t++) begin
        wait_arr[t]  = (t >= tbl[i].w_lo && t <= tbl[i].w_hi);
        valid_arr[t] = !(t >= tbl[i].v_lo && t <= tbl[i].v_hi);
      end
      for (int j = 0; j < 1024; j++) wdata[j] = 16'($urandom);
      if (i == 0) begin
        wdata[0] = 16'h1234;
        wdata[1] = 16'h5678;
      end
      resp_arr[0] = 16'($urandom);
      resp_arr[1] = 16'hA5A5;
      for (int j = 2; j < 1025; j++) resp_arr[j] = 16'(j - 1);
      run_txn(tbl[i].cmd, tbl[i].len, tbl[i].sel, o_str, o_wr, o_rd, o_done, o_ready);
      chk("tbl_ready_cycle", i, 40'(o_ready), 40'(tbl[i].e_rdy));
      chk("tbl_strobes", i, 40'(o_str), 40'(tbl[i].e_str));
      chk("tbl_wr_ready", i, 40'(o_wr), 40'(tbl[i].e_wr));
      chk("tbl_rd_valid", i, 40'(o_rd), 40'(tbl[i].e_rd));
      chk("tbl_done", i, 40'(o_done), 40'(tbl[i].e_done));
    end

    // Reset landing in the gap after the first data word.
    for (int j = 0; j < 1024; j++) wdata[j] = 16'($urandom);
    req_valid = 1'b1; req_cmd = 16'h0033; req_len = 10'd3; req_sel = 2'b01;
    wr_valid  = 1'b1; wr_data = wdata[0]; bus_wait = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk_sys);
    chk("mid_first_data", 5, 40'({bus_strobe, wr_ready, bus_din}), 40'({2'b11, wdata[0]}));
    @(posedge clk_sys);
    #1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("after_reset", 8, 40'({bus_en, bus_strobe, req_ready, done, rd_valid, wr_ready, bus_din}),
        40'({2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0}));
    cnt_done = 0;
    cnt_notready = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_sys);
      #1;
      @(negedge clk_sys);
      cnt_done += int'(done);
      cnt_notready += int'(!req_ready);
    end
    chk("after_reset_no_done", 0, 40'(cnt_done), 40'(0));
    chk("after_reset_ready", 0, 40'(cnt_notready), 40'(0));
    @(posedge clk_sys);
    #1;
    idle_inputs();
    last_din = '0;
    last_rd  = '0;
    for (int t = 0; t < 4096; t++) begin
      wait_arr[t]  = 1'b0;
      valid_arr[t] = 1'b1;
    end
    for (int j = 0; j < 1025; j++) resp_arr[j] = 16'($urandom);
    run_txn(16'h0034, 10'd2, 2'b01, o_str, o_wr, o_rd, o_done, o_ready);
    chk("post_reset_done", 0, 40'(o_done), 40'(1));
    chk("post_reset_ready", 0, 40'(o_ready), 40'(13));

`ifdef HPS_BUS_MASTER_TIMEOUT_EN
    req_valid = 1'b1; req_cmd = 16'h0099; req_len = 10'd2; req_sel = 2'b01;
    wr_valid  = 1'b1; wr_data = 16'h1111; bus_wait = 1'b1;
    err_c = -1; n_err = 0; cnt_done = 0; rdy_c = -1; n_str = 0; en17 = 2'b00; en18 = 2'b11;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk_sys);
      if (err && err_c < 0) err_c = c;
      n_err    += int'(err);
      cnt_done += int'(done);
      n_str    += int'(bus_strobe);
      if (c == 17) en17 = bus_en;
      if (c == 18) en18 = bus_en;
      if (c > 0 && req_ready && rdy_c < 0) rdy_c = c;
      @(posedge clk_sys);
      #1;
      req_valid = 1'b0;
    end
    chk("to_err_cycle", 0, 40'(err_c), 40'(17));
    chk("to_err_pulses", 0, 40'(n_err), 40'(1));
    chk("to_no_done", 0, 40'(cnt_done), 40'(0));
    chk("to_no_strobe", 0, 40'(n_str), 40'(0));
    chk("to_en", 0, 40'({en17, en18}), 40'({2'b01, 2'b00}));
    chk("to_ready", 0, 40'(rdy_c), 40'(20));
    idle_inputs();
`endif

    for (int i = 0; i < 25; i++) begin
      run = 0;
      for (int t = 0; t < 4096; t++) begin
        w = ($urandom_range(2) == 0) && (run < 6);
        run = w ? run + 1 : 0;
        wait_arr[t]  = w;
        valid_arr[t] = ($urandom_range(4) != 0);
      end
      for (int j = 0; j < 1024; j++) wdata[j] = 16'($urandom);
      for (int j = 0; j < 1025; j++) resp_arr[j] = 16'($urandom);
      run_txn(16'($urandom), 10'($urandom_range(12)), 2'($urandom), o_str, o_wr, o_rd, o_done,
              o_ready);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
